// File: rtl/telemetry_pkg.sv
// Shared definitions for the telemetry framer: FSM encoding, frame constants
// and the frame checksum.
package telemetry_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_LOAD      = 3'd1;
    localparam state_t ST_START     = 3'd2;
    localparam state_t ST_WAIT_BUSY = 3'd3;
    localparam state_t ST_WAIT_DONE = 3'd4;
    localparam state_t ST_GAP       = 3'd5;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN         = 5;
    // Cycles to wait for tx_ready to drop before assuming a zero-latency sender.
    localparam int         BUSY_TIMEOUT      = 4;

    function automatic logic [7:0] checksum8(input logic [7:0] seq,
                                             input logic [7:0] cc,
                                             input logic [7:0] dc);
        return seq + cc + dc;
    endfunction

endpackage

// File: rtl/period_tick_gen.sv
// Free-running period counter with enable gate; emits a one-cycle tick on the
// last count of each period. Held at zero while disabled.
module period_tick_gen #(
    parameter int unsigned PERIOD = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/telemetry_framer.sv
// Periodically snapshots count/duty values and streams a 5-byte frame
// (sync, seq, cc, dc, checksum) to a byte UART sender.
module telemetry_framer
    import telemetry_pkg::*;
#(
    parameter int unsigned FRAME_PERIOD = 100000,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned BYTE_GAP     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] cc_value,
    input  logic [7:0] dc_value,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    output logic       busy,
    output logic [7:0] seq_num,
    output logic [7:0] overrun_cnt,
    output state_t     fsm_state
);

    // Sender handshake: tx_start is a one-cycle request issued only while
    // tx_ready = 1 and with tx_byte already stable; the sender acknowledges by
    // dropping tx_ready and signals completion by raising it again.

    localparam int GAP_W = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    state_t           state;
    state_t           next_state;
    logic             tick;
    logic             byte_done;
    logic [2:0]       byte_idx;
    logic [7:0]       seq_reg;
    logic [7:0]       snap_cc;
    logic [7:0]       snap_dc;
    logic [7:0]       byte_mux;
    logic [1:0]       wb_cnt;
    logic [GAP_W-1:0] gap_cnt;

    period_tick_gen #(
        .PERIOD (FRAME_PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // byte_done marks the next-byte decision, taken either directly after
    // ready returns or at the end of the inter-byte gap.
    always_comb begin
        next_state = state;
        byte_done  = 1'b0;
        case (state)
            ST_IDLE:      if (tick) next_state = ST_LOAD;
            ST_LOAD:      next_state = ST_START;
            ST_START:     if (tx_ready) next_state = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!tx_ready || wb_cnt == 2'(BUSY_TIMEOUT - 1)) begin
                    next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    if (BYTE_GAP > 0) next_state = ST_GAP;
                    else              byte_done  = 1'b1;
                end
            end
            ST_GAP:       if (gap_cnt == GAP_W'(BYTE_GAP - 1)) byte_done = 1'b1;
            default:      next_state = ST_IDLE;
        endcase
        if (byte_done) begin
            next_state = (byte_idx == LAST_IDX) ? ST_IDLE : ST_LOAD;
        end
    end

    always_comb begin
        tx_start  = (state == ST_START) && tx_ready;
        busy      = (state != ST_IDLE);
        fsm_state = state;
    end

    always_comb begin
        case (byte_idx)
            3'd0:    byte_mux = SYNC_BYTE;
            3'd1:    byte_mux = seq_reg;
            3'd2:    byte_mux = snap_cc;
            3'd3:    byte_mux = snap_dc;
            default: byte_mux = checksum8(seq_reg, snap_cc, snap_dc);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte     <= '0;
            seq_num     <= '0;
            overrun_cnt <= '0;
            seq_reg     <= '0;
            snap_cc     <= '0;
            snap_dc     <= '0;
            byte_idx    <= '0;
            wb_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            if (tick && state == ST_IDLE) begin
                snap_cc <= cc_value;
                snap_dc <= dc_value;
            end
            // A tick that cannot start a frame is dropped and counted.
            if (tick && state != ST_IDLE && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (state == ST_LOAD) begin
                tx_byte <= byte_mux;
            end
            wb_cnt  <= (state == ST_WAIT_BUSY) ? wb_cnt + 2'd1 : 2'd0;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (byte_done) begin
                if (byte_idx == LAST_IDX) begin
                    seq_num  <= seq_reg;
                    seq_reg  <= seq_reg + 8'd1;
                    byte_idx <= 3'd0;
                end else begin
                    byte_idx <= byte_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: UART sender model with programmable
// ready latency, byte scoreboard and immediate-assertion checks.
module tb_telemetry_framer;
    import telemetry_pkg::*;

    localparam int PERIOD = 50;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] cc_value;
    logic [7:0] dc_value;
    logic       tx_ready;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       busy;
    logic [7:0] seq_num;
    logic [7:0] overrun_cnt;
    state_t     fsm_state;

    int n_assert = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int starts   = 0;
    int lat      = 10;
    logic [7:0] exp_q[$];

    telemetry_framer #(
        .FRAME_PERIOD (PERIOD),
        .SYNC_BYTE    (8'hA5),
        .BYTE_GAP     (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .cc_value    (cc_value),
        .dc_value    (dc_value),
        .tx_ready    (tx_ready),
        .tx_byte     (tx_byte),
        .tx_start    (tx_start),
        .busy        (busy),
        .seq_num     (seq_num),
        .overrun_cnt (overrun_cnt),
        .fsm_state   (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] s, input logic [7:0] c, input logic [7:0] d);
        logic [7:0] cs;
        cs = s + c + d;
        exp_q.push_back(8'hA5);
        exp_q.push_back(s);
        exp_q.push_back(c);
        exp_q.push_back(d);
        exp_q.push_back(cs);
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n;
        n = 0;
        while (rx_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rx_timeout", 32'(rx_cnt >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // UART sender model: accepts tx_start while ready, drops ready on the
    // following cycle for lat cycles (lat = 0 keeps ready high throughout).
    initial begin
        logic       s_start;
        logic       s_rdy;
        logic [7:0] s_byte;
        logic       pend;
        int         lat_cnt;
        tx_ready = 1'b1;
        pend     = 1'b0;
        lat_cnt  = 0;
        forever begin
            @(negedge clk);
            s_start = tx_start;
            s_rdy   = tx_ready;
            s_byte  = tx_byte;
            if (s_start) starts++;
            if (s_start && !s_rdy) check("start_while_not_ready", 32'(s_rdy), 1);
            if (pend) begin
                pend = 1'b0;
                if (lat > 0) begin
                    tx_ready = 1'b0;
                    lat_cnt  = lat;
                end
            end else if (!tx_ready) begin
                lat_cnt--;
                if (lat_cnt <= 0) tx_ready = 1'b1;
            end
            if (s_start && s_rdy) begin
                rx_cnt++;
                pend = 1'b1;
                if (exp_q.size() == 0) check("unexpected_byte", 32'(exp_q.size()), 1);
                else                   check("frame_byte", s_byte, exp_q.pop_front());
            end
        end
    end

    initial begin
        int base;
        int n;
        int s0;
        logic [7:0] o1;

        rst_n    = 1'b0;
        enable   = 1'b0;
        cc_value = 8'h12;
        dc_value = 8'h34;
        repeat (2) @(negedge clk);
        check("reset_tx_byte", tx_byte, 0);
        check("reset_tx_start", tx_start, 0);
        check("reset_busy", busy, 0);
        check("reset_seq_num", seq_num, 0);
        check("reset_overrun", overrun_cnt, 0);
        check("reset_state", fsm_state, ST_IDLE);
        rst_n = 1'b1;

        // Two frames with a 10-cycle sender.
        push_frame(8'h00, 8'h12, 8'h34);
        push_frame(8'h01, 8'h12, 8'h34);
        @(negedge clk);
        enable = 1'b1;
        wait_rx(10, 1000);
        wait_idle(200);
        enable = 1'b0;
        check("seq_after_two", seq_num, 1);

        // Snapshot timing: change on tick cycle captured, change after ignored.
        repeat (5) @(negedge clk);
        push_frame(8'h02, 8'h56, 8'h34);
        enable = 1'b1;
        repeat (PERIOD - 1) @(posedge clk);
        @(negedge clk);
        check("busy_before_tick", busy, 0);
        cc_value = 8'h56;
        @(negedge clk);
        check("busy_after_tick", busy, 1);
        cc_value = 8'hFF;
        wait_rx(15, 1000);
        wait_idle(200);
        enable   = 1'b0;
        cc_value = 8'h12;

        // enable dropped during byte 1: frame completes, then silence.
        repeat (5) @(negedge clk);
        push_frame(8'h03, 8'h12, 8'h34);
        base   = rx_cnt;
        enable = 1'b1;
        wait_rx(base + 2, 1000);
        enable = 1'b0;
        wait_rx(base + 5, 1000);
        wait_idle(200);
        s0 = starts;
        repeat (3 * PERIOD) @(negedge clk);
        check("no_start_after_disable", starts, s0);
        check("seq_after_disable", seq_num, 3);

        // Asynchronous reset during byte 2.
        push_frame(8'h04, 8'h12, 8'h34);
        base   = rx_cnt;
        enable = 1'b1;
        wait_rx(base + 3, 1000);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_tx_start", tx_start, 0);
        check("midreset_busy", busy, 0);
        check("midreset_tx_byte", tx_byte, 0);
        check("midreset_seq_num", seq_num, 0);
        check("midreset_overrun", overrun_cnt, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(8'h00, 8'h12, 8'h34);
        base = rx_cnt;
        wait_rx(base + 5, 1000);
        wait_idle(200);
        enable = 1'b0;
        check("seq_after_reset_frame", seq_num, 0);

        // Zero-latency sender: ready never drops.
        repeat (5) @(negedge clk);
        lat = 0;
        push_frame(8'h01, 8'h12, 8'h34);
        base   = rx_cnt;
        enable = 1'b1;
        wait_rx(base + 5, 1000);
        wait_idle(200);
        enable = 1'b0;
        check("seq_zero_latency", seq_num, 1);
        lat = 10;

        // Slow sender: overrun counting and saturation.
        do_reset();
        lat = 200;
        for (int k = 0; k < 20; k++) push_frame(8'(k), 8'h12, 8'h34);
        base   = rx_cnt;
        enable = 1'b1;
        wait_rx(base + 1, 1000);
        repeat (20) @(negedge clk);
        o1 = overrun_cnt;
        repeat (PERIOD) @(negedge clk);
        check("busy_during_window", busy, 1);
        check("overrun_plus_one", overrun_cnt, 32'(o1) + 1);
        n = 0;
        while (overrun_cnt !== 8'hFF && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("overrun_reaches_255", overrun_cnt, 8'hFF);
        repeat (3 * PERIOD) @(negedge clk);
        check("overrun_saturated", overrun_cnt, 8'hFF);
        enable = 1'b0;
        wait_idle(1500);
        exp_q.delete();

        // Sequence wrap over 257 frames with cc = dc = 0.
        do_reset();
        lat      = 2;
        cc_value = 8'h00;
        dc_value = 8'h00;
        for (int k = 0; k < 257; k++) push_frame(8'(k), 8'h00, 8'h00);
        base   = rx_cnt;
        enable = 1'b1;
        wait_rx(base + 257 * 5, 20000);
        wait_idle(200);
        enable = 1'b0;
        check("seq_after_wrap", seq_num, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/telemetry_framer.md
Name: telemetry_framer

Overview:
- Sits between the measurement stage (counting circuit and duty-cycle circuit) and the byte-level UART transmitter.
- On a programmable period tick it snapshots the 8-bit count value and the 8-bit duty-cycle value.
- It builds a 5-byte frame: sync, sequence, count, duty, checksum.
- It hands the frame to the UART sender one byte at a time using a start/ready handshake, replacing the free-running `start_send = 1` usage.

Parameters:
- FRAME_PERIOD, 100000: clock cycles between snapshot ticks. Must be ≥ 2.
- SYNC_BYTE, 8'hA5: first byte of every frame.
- BYTE_GAP, 0: idle cycles inserted after each byte's ready returns high.

Ports:
- clk  in  1  system clock (DCM CLK0 domain)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = period timer runs and frames are produced; 0 = timer held at 0, any frame in progress completes
- cc_value  in  8  count value from the counting circuit
- dc_value  in  8  duty-cycle value from the duty-cycle circuit
- tx_ready  in  1  UART sender idle/ready
- tx_byte  out  8  byte presented to the UART sender
- tx_start  out  1  one-cycle start pulse to the UART sender
- busy  out  1  frame in progress
- seq_num  out  8  sequence number of the last completed frame
- overrun_cnt  out  8  saturating count of ticks dropped because a frame was still in progress

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM = IDLE, timer = 0, internal sequence register = 0.
- Period timer:
  - Counts 0..FRAME_PERIOD-1 while enable = 1.
  - Raises internal tick for one cycle at FRAME_PERIOD-1, then wraps to 0.
- Tick handling:
  - Tick in IDLE: latch cc_value and dc_value into a snapshot register that same cycle; go to LOAD.
  - Tick in any other state: snapshot unchanged; overrun_cnt += 1, saturating at 255.
- FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP.
  - LOAD: select byte index i (0..4) into tx_byte. Go to START.
    - Byte 0 = SYNC_BYTE.
    - Byte 1 = sequence register.
    - Byte 2 = snapshot cc.
    - Byte 3 = snapshot dc.
    - Byte 4 = (seq + cc + dc) mod 256.
  - START: if tx_ready = 1, assert tx_start for exactly one cycle and go to WAIT_BUSY; else hold.
  - WAIT_BUSY: wait for tx_ready = 0, then go to WAIT_DONE.
    - If tx_ready is still 1 after 4 cycles, treat the byte as accepted and go to WAIT_DONE. This tolerates a sender with zero-latency ready.
  - WAIT_DONE: wait for tx_ready = 1.
    - Then go to GAP if BYTE_GAP > 0, else go straight to the next-byte decision.
  - GAP: count BYTE_GAP cycles, then make the next-byte decision.
  - Next-byte decision:
    - If i < 4: i += 1, go to LOAD.
    - If i = 4: seq_num <= sequence register; sequence register += 1 (wraps 255 -> 0); i <= 0; go to IDLE.
- tx_byte is stable from LOAD until the START -> WAIT_BUSY transition; it is not changed while tx_start is high.
- busy = 1 in every state except IDLE.
- enable deasserted mid-frame: the frame finishes normally; no new tick occurs; the timer is held at 0.
- Reset mid-frame: frame aborted immediately; tx_start forced to 0; the sender may finish its current byte on its own.
- A tick and the completion of byte 4 in the same cycle: the FSM is not yet in IDLE, so the tick counts as an overrun.

Decomposition:
- Shared package `telemetry_pkg` holds:
  - the state encoding localparams;
  - SYNC_BYTE default;
  - frame length constant 5;
  - checksum function (8-bit modular sum).
- One natural sub-module: `period_tick_gen`, holding the counter, the enable gate and the one-cycle tick output. It can be reused by the display refresh logic.
- The FSM, byte mux and overrun counter stay in `telemetry_framer`.

Test Plan:
- FRAME_PERIOD = 50, cc = 8'h12, dc = 8'h34, sender model with ready low for 10 cycles after start:
  - first frame bytes are A5, 00, 12, 34, 46;
  - second frame bytes are A5, 01, 12, 34, 47;
  - seq_num reads 1 after the second frame.
- cc changes to 8'hFF one cycle after the tick: frame still carries the snapshot 8'h12. A change in the same cycle as the tick is captured.
- Sender busy 200 cycles per byte, FRAME_PERIOD = 50: overrun_cnt increments each dropped tick and saturates at 255 in a long run. No tx_start while tx_ready = 0.
- Sequence wrap: run 257 frames with cc = dc = 0. Frame 256 carries seq 8'hFF with checksum FF. Frame 257 carries seq 00 with checksum 00.
- rst_n pulled low during byte 2: all outputs 0 within the same cycle (async). After release the next frame starts with A5, 00.
- enable dropped during byte 1: the frame completes all 5 bytes, then no further tx_start for 3×FRAME_PERIOD cycles.
